normalize_scheduler: RTL and testbench
======================================

// Module: normalize_scheduler
// PURPOSE
// Shares one vector-normalization pipeline (4x square, adder tree, sqrt, 4x divide; fixed latency, no stall) among
// NUM_REQ requesters. Round-robin arbitration issues one 4-element vector per cycle. In-order tag tracking routes
// each result back with its requester ID. Credit-based issue into a result FIFO absorbs output backpressure.
// Sits between requester ports and the pipeline's i_valid/A..D inputs and o_valid/output_final_* outputs.
// PARAMETERS
// NUM_REQ     4   number of requesters (2..8)
// DATAWIDTH   16  element width in, 8.8 fixed point; results are DATAWIDTH+1 bits
// FIFO_DEPTH  8   result FIFO entries; also max in-flight + buffered results (power of 2, >= 2)
// ID_W        $clog2(NUM_REQ)  requester ID width (localparam)
// PORTS
// clk          in   1                     clock
// rst          in   1                     synchronous active-high reset
// req_valid    in   NUM_REQ               per-requester vector valid
// req_ready    out  NUM_REQ               one-hot grant; transfer when valid&ready
// req_data     in   NUM_REQ*4*DATAWIDTH   per-requester {A,B,C,D}; requester i at slice i
// pipe_i_valid out  1                     issue strobe to pipeline (registered)
// pipe_data    out  4*DATAWIDTH           {A,B,C,D} to pipeline (registered)
// pipe_o_valid in   1                     pipeline result valid (o_valid_final_A)
// pipe_result  in   4*(DATAWIDTH+1)       {Qa,Qb,Qc,Qd} from pipeline
// rsp_valid    out  1                     result FIFO non-empty
// rsp_ready    in   1                     consumer accepts result
// rsp_id       out  ID_W                  requester ID of head result
// rsp_data     out  4*(DATAWIDTH+1)       head result
// flush        in   1                     request drain (level or pulse, sampled in RUN)
// flush_done   out  1                     one-cycle pulse when drain complete
// tag_err      out  1                     sticky: pipe_o_valid with no in-flight tag
// BEHAVIOUR
// - Reset: req_ready=0, pipe_i_valid=0, pipe_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, flush_done=0, tag_err=0,
//   inflight=0, FIFO empty, RR pointer=0, state=RUN. Reset mid-operation discards in-flight tags and FIFO contents.
// - can_issue = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH). Outstanding results never exceed FIFO_DEPTH.
// - Arbiter: combinational; grants the first valid requester at or after rr_ptr, modulo NUM_REQ.
//   req_ready = grant & {NUM_REQ{can_issue}}. req_ready is never asserted to a requester with req_valid low.
//   On issue, rr_ptr <= granted+1 (wraps NUM_REQ-1 -> 0). No issue leaves rr_ptr unchanged.
// - Issue: next cycle pipe_i_valid=1 and pipe_data=granted req_data. The granted ID is pushed to the tag queue,
//   an in-order queue of FIFO_DEPTH entries. pipe_data holds its value when no issue occurs.
// - Return: pipe_o_valid pops the tag queue and pushes {tag, pipe_result} into the result FIFO.
//   Issue and return in the same cycle: inflight unchanged.
//   pipe_o_valid with tag queue empty: result dropped, tag_err<=1 until rst.
// - Result FIFO: show-ahead. rsp_valid = !empty. Pop on rsp_valid&rsp_ready. Push and pop allowed in the same cycle,
//   including when full, since credits guarantee space.
// - FSM: RUN -flush-> DRAIN. DRAIN: no issue, returns and pops continue.
//   DRAIN -(inflight==0 && FIFO empty)-> DONE. DONE: flush_done=1 for one cycle -> RUN.
//   If inflight==0 and FIFO is empty when flush is sampled, DRAIN lasts exactly one cycle.
// - Latency: req handshake -> pipe_i_valid is 1 cycle. pipe_o_valid -> rsp_valid is 1 cycle (FIFO was empty).
// TESTING
// 1) Single req0 {A..D}=0x0100, stub pipe latency 8 returns 0x080 each -> pipe_i_valid at T+1;
//    rsp_valid at T+10, rsp_id=0, rsp_data=4x0x080.
// 2) All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle;
//    rsp_ids follow the same order.
// 3) rsp_ready=0, FIFO_DEPTH=8, continuous requests -> exactly 8 issues, then req_ready=0.
//    After rsp_ready=1, one new issue per popped result; no loss.
// 4) flush with 3 in flight -> no grants in DRAIN; 3 results delivered; flush_done pulses once;
//    grants resume the next cycle.
// 5) Inject pipe_o_valid with nothing in flight -> tag_err=1, no rsp_valid; stays 1 until rst.
// 6) rst asserted with 5 in flight -> all outputs at reset values next cycle.
//    Late pipe_o_valid after reset sets tag_err.

Source files
------------

// File: rtl/normalize_scheduler_if.sv
// Requester, pipeline and response signals of the normalization scheduler.
// The scheduler uses the slave view; the requester/pipeline/consumer side uses master.
interface normalize_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*4*DATAWIDTH-1:0] req_data;
  logic                           pipe_i_valid;
  logic [4*DATAWIDTH-1:0]         pipe_data;
  logic                           pipe_o_valid;
  logic [4*(DATAWIDTH+1)-1:0]     pipe_result;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [4*(DATAWIDTH+1)-1:0]     rsp_data;
  logic                           flush;
  logic                           flush_done;
  logic                           tag_err;

  modport master (
    output req_valid, req_data, pipe_o_valid, pipe_result, rsp_ready, flush,
    input  req_ready, pipe_i_valid, pipe_data, rsp_valid, rsp_id, rsp_data,
           flush_done, tag_err
  );

  modport slave (
    input  req_valid, req_data, pipe_o_valid, pipe_result, rsp_ready, flush,
    output req_ready, pipe_i_valid, pipe_data, rsp_valid, rsp_id, rsp_data,
           flush_done, tag_err
  );
endinterface

// File: rtl/normalize_scheduler.sv
// Round-robin sharing of a fixed-latency normalization pipeline among NUM_REQ requesters,
// with in-order tag tracking and credit-limited issue into a show-ahead result FIFO.
module normalize_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATAWIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  normalize_scheduler_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VW   = 4 * DATAWIDTH;
  localparam int RW   = 4 * (DATAWIDTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int EW   = ID_W + RW;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [VW-1:0]      sel_data;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        outstanding;
  logic               can_issue;
  logic               issue;
  logic               push;
  logic               pop;
  logic [PW-1:0]      tag_wr, tag_rd;
  logic [PW-1:0]      fifo_wr, fifo_rd;
  logic [ID_W-1:0]    tag_q    [FIFO_DEPTH];
  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]      head;

  // First valid requester at or after rr_ptr, scanning modulo NUM_REQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + int'(k)) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) sel_data = bus.req_data[k*VW +: VW];
    end
  end

  // Credits cover both in-flight and buffered results, so a push always finds space.
  assign outstanding   = {1'b0, inflight} + {1'b0, fifo_count};
  assign can_issue     = (state == RUN) && (outstanding < (CW+1)'(FIFO_DEPTH));
  assign bus.req_ready = rst ? '0 : (grant & {NUM_REQ{can_issue}});
  assign issue         = |bus.req_ready;
  assign push          = bus.pipe_o_valid && (inflight != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign head          = fifo_mem[fifo_rd];
  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? head[EW-1 -: ID_W] : '0;
  assign bus.rsp_data  = bus.rsp_valid ? head[RW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (issue) tag_q[tag_wr] <= grant_id;
    if (push)  fifo_mem[fifo_wr] <= {tag_q[tag_rd], bus.pipe_result};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      rr_ptr           <= '0;
      inflight         <= '0;
      fifo_count       <= '0;
      tag_wr           <= '0;
      tag_rd           <= '0;
      fifo_wr          <= '0;
      fifo_rd          <= '0;
      bus.pipe_i_valid <= 1'b0;
      bus.pipe_data    <= '0;
      bus.flush_done   <= 1'b0;
      bus.tag_err      <= 1'b0;
    end else begin
      bus.pipe_i_valid <= issue;
      if (issue) begin
        bus.pipe_data <= sel_data;
        tag_wr        <= tag_wr + 1'b1;
        rr_ptr        <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (push) begin
        tag_rd  <= tag_rd + 1'b1;
        fifo_wr <= fifo_wr + 1'b1;
      end
      if (bus.pipe_o_valid && (inflight == '0)) bus.tag_err <= 1'b1;
      if (pop) fifo_rd <= fifo_rd + 1'b1;
      inflight   <= inflight + CW'(issue) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      bus.flush_done <= 1'b0;
      case (state)
        RUN:   if (bus.flush) state <= DRAIN;
        DRAIN: if ((inflight == '0) && (fifo_count == '0)) begin
          state          <= DONE;
          bus.flush_done <= 1'b1;
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_normalize_scheduler.sv
// Directed bench for normalize_scheduler with an 8-cycle stub pipeline that halves each element.
module tb_normalize_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int DATAWIDTH  = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int VW         = 4 * DATAWIDTH;
  localparam int RW         = 4 * (DATAWIDTH + 1);

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n, cnt, got, dgrant, dones, bad;
  logic [3:0] eg;

  normalize_scheduler_if #(.NUM_REQ(NUM_REQ), .DATAWIDTH(DATAWIDTH)) bus ();

  normalize_scheduler #(
    .NUM_REQ(NUM_REQ), .DATAWIDTH(DATAWIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Stub pipeline: not reset, so returns issued before a reset still arrive afterwards.
  logic [7:0]    dv       = '0;
  logic [RW-1:0] dd [8];
  logic          inj      = 1'b0;
  logic [RW-1:0] inj_data = '0;

  function automatic logic [RW-1:0] half(input logic [VW-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int e = 0; e < 4; e++) r[e*17 +: 17] = {1'b0, v[e*16 +: 16]} >> 1;
    return r;
  endfunction

  function automatic logic [VW-1:0] req_vec(input int i);
    logic [15:0] e;
    e = 16'(32'h200 * (i + 1));
    return {4{e}};
  endfunction

  function automatic logic [RW-1:0] exp_res(input int id);
    logic [16:0] q;
    q = 17'(32'h100 * (id + 1));
    return {4{q}};
  endfunction

  always @(posedge clk) begin
    dv    <= {dv[6:0], bus.pipe_i_valid === 1'b1};
    dd[0] <= half(bus.pipe_data);
    for (int i = 1; i < 8; i++) dd[i] <= dd[i-1];
  end
  assign bus.pipe_o_valid = dv[7] | inj;
  assign bus.pipe_result  = inj ? inj_data : dd[7];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int w;
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 40) begin
      @(negedge clk); #1;
      w++;
    end
    check(tag, bus.rsp_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_pipe_i_valid", bus.pipe_i_valid, 1'b0);
    check("rst_pipe_data", bus.pipe_data, '0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, '0);
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_flush_done", bus.flush_done, 1'b0);
    check("rst_tag_err", bus.tag_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1) single request from requester 0
    bus.req_data[0 +: VW] = {4{16'h0100}};
    bus.req_valid = 4'b0001;
    #1;
    check("t1_ready", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("t1_pipe_i_valid", bus.pipe_i_valid, 1'b1);
    check("t1_pipe_data", bus.pipe_data, {4{16'h0100}});
    check("t1_ready_off", bus.req_ready, 4'b0000);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("t1_latency", n, 9);
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_rsp_data", bus.rsp_data, {4{17'h080}});
    @(negedge clk); #1;
    check("t1_popped", bus.rsp_valid, 1'b0);

    // 2) all requesters valid; rr_ptr is 1 after granting requester 0
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*VW +: VW] = req_vec(i);
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      eg = 4'(1 << ((1 + k) % 4));
      check("t2_grant", bus.req_ready, eg);
      @(negedge clk);
    end
    bus.req_valid = '0;
    for (int j = 0; j < 8; j++) begin
      wait_rsp("t2_valid");
      check("t2_rsp_id", bus.rsp_id, (1 + j) % 4);
      check("t2_rsp_data", bus.rsp_data, exp_res((1 + j) % 4));
      @(negedge clk);
    end

    // 3) backpressure: credits stop issue at FIFO_DEPTH outstanding
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (|bus.req_ready) cnt++;
      @(negedge clk);
    end
    #1;
    check("t3_issue_count", cnt, FIFO_DEPTH);
    check("t3_ready_blocked", bus.req_ready, 4'b0000);
    check("t3_fifo_valid", bus.rsp_valid, 1'b1);
    check("t3_head0", bus.rsp_id, 1);
    bus.rsp_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); #1;
      check("t3_credit", |bus.req_ready, 1'b1);
      check("t3_head", bus.rsp_id, (1 + k) % 4);
    end
    @(negedge clk);
    bus.req_valid = '0;
    for (int j = 0; j < 7; j++) begin
      wait_rsp("t3_valid");
      check("t3_rsp_id", bus.rsp_id, (1 + j) % 4);
      check("t3_rsp_data", bus.rsp_data, exp_res((1 + j) % 4));
      @(negedge clk);
    end

    // 4) flush with three in flight; rr_ptr is 0 here
    bus.req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      #1;
      eg = 4'(1 << k);
      check("t4_grant", bus.req_ready, eg);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = '1;
    got = 0; dgrant = 0; dones = 0; n = 0;
    while (dones == 0 && n < 60) begin
      #1;
      if (|bus.req_ready) dgrant++;
      if (bus.rsp_valid) begin
        check("t4_rsp_id", bus.rsp_id, got);
        got++;
      end
      if (bus.flush_done) dones++;
      @(negedge clk);
      n++;
    end
    #1;
    check("t4_results", got, 3);
    check("t4_drain_grants", dgrant, 0);
    check("t4_done_seen", dones, 1);
    check("t4_resume", bus.req_ready, 4'b1000);
    check("t4_done_pulse", bus.flush_done, 1'b0);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp("t4_valid");
    check("t4_resume_id", bus.rsp_id, 3);
    @(negedge clk);

    // 5) spurious return with nothing in flight
    inj      = 1'b1;
    inj_data = {4{17'h1_2345}};
    @(negedge clk);
    inj = 1'b0;
    #1;
    check("t5_tag_err", bus.tag_err, 1'b1);
    check("t5_no_rsp", bus.rsp_valid, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("t5_sticky", bus.tag_err, 1'b1);
    check("t5_no_rsp_later", bus.rsp_valid, 1'b0);

    // 6) reset with five in flight, then late returns
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      eg = 4'(1 << (k % 4));
      check("t6_grant", bus.req_ready, eg);
      @(negedge clk);
    end
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_pipe_i_valid", bus.pipe_i_valid, 1'b0);
    check("t6_pipe_data", bus.pipe_data, '0);
    check("t6_tag_err", bus.tag_err, 1'b0);
    check("t6_rsp_valid", bus.rsp_valid, 1'b0);
    check("t6_rsp_id", bus.rsp_id, '0);
    check("t6_rsp_data", bus.rsp_data, '0);
    check("t6_flush_done", bus.flush_done, 1'b0);
    rst = 1'b0;
    n = 0; bad = 0;
    while (bus.tag_err !== 1'b1 && n < 30) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) bad++;
      n++;
    end
    check("t6_late_err", bus.tag_err, 1'b1);
    check("t6_late_time", n, 4);
    repeat (8) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) bad++;
    end
    check("t6_no_rsp", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
